// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction fetch stage.
// Holds the PC, issues word reads to instruction memory under a credit limit,
// queues returned words in order with their PCs, and hands them to decode over
// a valid/ready handshake. A redirect flushes the queue and marks every
// in-flight response for discard before fetching resumes at the new target.
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {FETCH, STALL} state_t;

  state_t state_q, state_d;

  logic [31:0]      pc_q;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [PTR_W-1:0] q_wr, q_rd;
  logic [PTR_W-1:0] t_wr, t_rd;

  // Instruction queue (data + PC) and the PC tag FIFO for in-flight requests.
  logic [31:0] q_data [QUEUE_DEPTH];
  logic [31:0] q_pc   [QUEUE_DEPTH];
  logic [31:0] tag_pc [QUEUE_DEPTH];

  logic             accept;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] used_next;

  // Decode this cycle's events and the occupancy they leave behind.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    accept     = imem_req_valid & imem_req_ready;
    rsp_keep   = imem_rsp_valid & (discard == '0);
    rsp_drop   = imem_rsp_valid & (discard != '0);
    push       = rsp_keep & ~redirect_valid;
    pop        = inst_valid & inst_ready & ~redirect_valid;
    used       = q_count + outstanding;
    out_next   = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    count_next = redirect_valid ? '0 : (q_count + CNT_W'(push) - CNT_W'(pop));
    used_next  = count_next + out_next;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments; reset is synchronous, sampled on the clock edge.
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // FSM next state: stall once an accept uses the last credit, resume when one frees.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: if (accept && used_next >= DEPTH_C) state_d = STALL;
        STALL: if (used_next < DEPTH_C)            state_d = FETCH;
        default:                                   state_d = FETCH;
      endcase
    end
  end

  // FSM outputs: request while fetching with a free credit and no redirect pending.
  always_comb begin
    imem_req_valid = reset_n && (state_q == FETCH) && (used < DEPTH_C) && !redirect_valid;
    imem_req_addr  = pc_q;
  end

  // PC, credit counters and queue/tag pointers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      q_count     <= '0;
      outstanding <= '0;
      discard     <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      t_wr        <= '0;
      t_rd        <= '0;
    end else begin
      outstanding <= out_next;
      q_count     <= count_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        pc_q    <= redirect_pc & ~32'h3;
        discard <= out_next;
        q_wr    <= '0;
        q_rd    <= '0;
        t_wr    <= '0;
        t_rd    <= '0;
      end else begin
        if (accept) begin
          pc_q <= pc_q + 32'd4;
          t_wr <= t_wr + 1'b1;
        end
        if (rsp_drop) discard <= discard - 1'b1;
        if (rsp_keep) t_rd <= t_rd + 1'b1;
        if (push)     q_wr <= q_wr + 1'b1;
        if (pop)      q_rd <= q_rd + 1'b1;
      end
    end
  end

  // Queue and tag storage; occupancy is tracked by the pointers above.
  always_ff @(posedge clock) begin
    // NOTE: storage arrays are not reset; stale entries are never visible because the counters are.
    if (accept) tag_pc[t_wr] <= pc_q;
    if (push) begin
      q_data[q_wr] <= imem_rsp_data;
      q_pc[q_wr]   <= tag_pc[t_rd];
    end
  end

  // Decode-side outputs straight from the queue head, zero when empty.
  always_comb begin
    inst_valid = (q_count != '0);
    inst       = inst_valid ? q_data[q_rd] : 32'h0;
    inst_pc    = inst_valid ? q_pc[q_rd]   : 32'h0;
    opcode     = inst[6:0];
  end

  // A kept response must always find room; the credit limit guarantees it.
  assert property (@(posedge clock) disable iff (!reset_n)
                   (imem_rsp_valid && discard == '0) |-> (q_count != DEPTH_C));

endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch: directed bench for rv32i_fetch with an in-order memory model
// and a scoreboard of expected instruction PCs checked by a separate monitor.
module tb_rv32i_fetch;

  logic        clock;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;

  rv32i_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          tests   = 0;
  int          errors  = 0;
  int          pop_cnt = 0;
  int          cyc     = 0;
  int          mem_lat = 1;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_q[$];

  // Instruction word stored at an address; varies the low opcode bits too.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input int k, input int budget);
    int n;
    n = 0;
    while (pop_cnt < k && n < budget) begin
      tick();
      n++;
    end
    check("progress", 32'(pop_cnt >= k), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    pop_cnt = 0;
    repeat (cycles) tick();
    acc_log.delete();
    reset_n = 1'b1;
  endtask

  // Memory model: logs accepted requests, answers in order after mem_lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      @(negedge clock);
      if (!reset_n) begin
        pend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        acc_log.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: every instruction decode consumes is compared with the scoreboard head.
  initial begin
    logic [31:0] e;
    logic [31:0] w;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_inst: got pc %h, required no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          check("inst_pc", inst_pc, e);
          check("inst", inst, w);
          check("opcode", {25'd0, opcode}, {25'd0, w[6:0]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_lat        = 1;

    // Reset values while reset is held.
    tick();
    tick();
    @(negedge clock);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_opcode", {25'd0, opcode}, 32'd0);

    // Streaming from RESET_PC with 1-cycle memory, cycle-exact start-up.
    tick();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    acc_log.delete();
    pop_cnt = 0;
    reset_n = 1'b1;
    @(negedge clock);
    check("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    check("c0_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    @(negedge clock);
    check("c1_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("c1_req_addr", imem_req_addr, 32'h4);
    tick();
    @(negedge clock);
    check("c2_credit_stall", {31'd0, imem_req_valid}, 32'd0);
    check("c2_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("c2_inst_pc", inst_pc, 32'h0);
    tick();
    @(negedge clock);
    check("c3_pushpop_valid", {31'd0, inst_valid}, 32'd1);
    check("c3_pushpop_pc", inst_pc, 32'h4);
    check("c3_req_addr", imem_req_addr, 32'h8);
    tick();
    run_until(10, 100);
    check("stream_acc0", acc_log[0], 32'h0);
    check("stream_acc1", acc_log[1], 32'h4);
    check("stream_acc2", acc_log[2], 32'h8);

    // Back-pressure: two accepts fill the credits, then fetch resumes at 0x8.
    inst_ready = 1'b0;
    do_reset(2);
    repeat (6) tick();
    @(negedge clock);
    check("bp_acc_count", 32'(acc_log.size()), 32'd2);
    check("bp_acc0", acc_log[0], 32'h0);
    check("bp_acc1", acc_log[1], 32'h4);
    check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("bp_head_pc", inst_pc, 32'h0);
    tick();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
    inst_ready = 1'b1;
    run_until(6, 100);
    check("bp_resume_addr", acc_log[2], 32'h8);

    // Redirect with two requests in flight: both responses dropped.
    mem_lat    = 3;
    inst_ready = 1'b1;
    do_reset(2);
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h1000 + 32'(i * 4));
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    @(negedge clock);
    check("rd_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("rd_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    run_until(4, 200);
    check("rd_acc0", acc_log[0], 32'h0);
    check("rd_acc1", acc_log[1], 32'h4);
    check("rd_acc2", acc_log[2], 32'h1000);

    // Back-to-back redirects: queued entry flushed, discard tracks the live response.
    mem_lat    = 2;
    inst_ready = 1'b0;
    do_reset(2);
    tick();
    tick();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h3008 + 32'(i * 4));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    inst_ready     = 1'b1;
    tick();
    redirect_pc = 32'h0000_3008;
    @(negedge clock);
    check("b2b_flush", {31'd0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("b2b_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("b2b_req_addr", imem_req_addr, 32'h3008);
    tick();
    run_until(4, 200);

    // PC wrap from 0xFFFF_FFFC to 0x0000_0000.
    mem_lat    = 1;
    inst_ready = 1'b1;
    do_reset(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    for (int i = 0; i < 12; i++) exp_q.push_back(32'hFFFF_FFFC + 32'(i * 4));
    tick();
    redirect_valid = 1'b0;
    run_until(6, 100);
    check("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
    check("wrap_acc1", acc_log[1], 32'h0);

    // One-cycle reset in the middle of the stream.
    reset_n = 1'b0;
    exp_q.delete();
    pop_cnt = 0;
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i * 4));
    tick();
    acc_log.delete();
    reset_n = 1'b1;
    @(negedge clock);
    check("mr_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("mr_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("mr_req_addr", imem_req_addr, 32'h0);
    tick();
    run_until(5, 100);
    check("mr_acc0", acc_log[0], 32'h0);
    check("mr_acc1", acc_log[1], 32'h4);

    inst_ready = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
